// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, synchronous flush with
// zero-control bubbles, and an optional two-entry skid buffer that registers in_ready.
module pipe_stage_reg #(
    parameter int DATA_W = 160,
    parameter int CTRL_W = 10,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [15:0]       stall_cnt
);

    logic        in_xfer;
    logic        out_xfer;
    logic [15:0] stall_cnt_reg;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            localparam logic [1:0] ST_EMPTY = 2'd0;
            localparam logic [1:0] ST_ONE   = 2'd1;
            localparam logic [1:0] ST_FULL  = 2'd2;

            logic [1:0]        state_reg;
            logic [1:0]        state_next;
            logic [CTRL_W-1:0] main_ctrl_reg;
            logic [DATA_W-1:0] main_data_reg;
            logic [CTRL_W-1:0] skid_ctrl_reg;
            logic [DATA_W-1:0] skid_data_reg;
            logic              in_ready_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg <= ST_EMPTY;
                end else begin
                    state_reg <= state_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                if (flush) begin
                    state_next = ST_EMPTY;
                end else begin
                    case (state_reg)
                        ST_EMPTY: if (in_xfer) state_next = ST_ONE;
                        ST_ONE: begin
                            if (in_xfer && !out_xfer)      state_next = ST_FULL;
                            else if (!in_xfer && out_xfer) state_next = ST_EMPTY;
                        end
                        ST_FULL:  if (out_xfer) state_next = ST_ONE;
                        default:  state_next = ST_EMPTY;
                    endcase
                end
            end

            // Payload registers follow the state transition; main_ctrl is zeroed whenever
            // the stage goes empty so out_ctrl reads as a bubble without extra gating.
            always_ff @(posedge clk) begin
                if (reset) begin
                    main_ctrl_reg <= '0;
                    main_data_reg <= '0;
                    skid_ctrl_reg <= '0;
                    skid_data_reg <= '0;
                    in_ready_reg  <= 1'b1;
                end else begin
                    in_ready_reg <= (state_next != ST_FULL);
                    if (flush) begin
                        main_ctrl_reg <= '0;
                        skid_ctrl_reg <= '0;
                    end else begin
                        case (state_reg)
                            ST_EMPTY: begin
                                if (in_xfer) begin
                                    main_ctrl_reg <= in_ctrl;
                                    main_data_reg <= in_data;
                                end
                            end
                            ST_ONE: begin
                                if (in_xfer && out_xfer) begin
                                    main_ctrl_reg <= in_ctrl;
                                    main_data_reg <= in_data;
                                end else if (in_xfer) begin
                                    skid_ctrl_reg <= in_ctrl;
                                    skid_data_reg <= in_data;
                                end else if (out_xfer) begin
                                    main_ctrl_reg <= '0;
                                end
                            end
                            ST_FULL: begin
                                if (out_xfer) begin
                                    main_ctrl_reg <= skid_ctrl_reg;
                                    main_data_reg <= skid_data_reg;
                                    skid_ctrl_reg <= '0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end

            always_comb begin
                out_valid = (state_reg != ST_EMPTY);
                in_ready  = in_ready_reg;
                occupancy = state_reg;
                out_ctrl  = main_ctrl_reg;
                out_data  = main_data_reg;
            end
        end else begin : g_single
            logic              valid_reg;
            logic [CTRL_W-1:0] ctrl_reg;
            logic [DATA_W-1:0] data_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_reg <= 1'b0;
                    ctrl_reg  <= '0;
                    data_reg  <= '0;
                end else if (flush) begin
                    valid_reg <= 1'b0;
                    ctrl_reg  <= '0;
                end else if (in_xfer) begin
                    valid_reg <= 1'b1;
                    ctrl_reg  <= in_ctrl;
                    data_reg  <= in_data;
                end else if (out_xfer) begin
                    valid_reg <= 1'b0;
                    ctrl_reg  <= '0;
                end
            end

            always_comb begin
                out_valid = valid_reg;
                in_ready  = ~valid_reg | out_ready;
                occupancy = {1'b0, valid_reg};
                out_ctrl  = ctrl_reg;
                out_data  = data_reg;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: one skid instance and one single-register instance,
// directed stimulus pushes expected payloads, negedge monitors pop and compare on each retire.
module tb_pipe_stage_reg;

    logic         clk;
    logic         reset;
    logic         in_valid1, in_ready1, flush1, out_valid1, out_ready1;
    logic [9:0]   in_ctrl1, out_ctrl1;
    logic [159:0] in_data1, out_data1;
    logic [1:0]   occ1;
    logic [15:0]  stall1;
    logic         in_valid0, in_ready0, flush0, out_valid0, out_ready0;
    logic [9:0]   in_ctrl0, out_ctrl0;
    logic [159:0] in_data0, out_data0;
    logic [1:0]   occ0;
    logic [15:0]  stall0;

    logic [169:0] exp1_q[$];
    logic [169:0] exp0_q[$];
    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    pipe_stage_reg #(.DATA_W(160), .CTRL_W(10), .SKID(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_ctrl(in_ctrl1), .in_data(in_data1), .flush(flush1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_ctrl(out_ctrl1), .out_data(out_data1),
        .occupancy(occ1), .stall_cnt(stall1)
    );

    pipe_stage_reg #(.DATA_W(160), .CTRL_W(10), .SKID(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_ctrl(in_ctrl0), .in_data(in_data0), .flush(flush0), .out_valid(out_valid0),
        .out_ready(out_ready0), .out_ctrl(out_ctrl0), .out_data(out_data0),
        .occupancy(occ0), .stall_cnt(stall0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [169:0] act, input logic [169:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic logic [159:0] pat(input logic [31:0] s);
        return {s, ~s, s + 32'd1, s ^ 32'h5a5a5a5a, s << 1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [9:0] c, input logic [159:0] d);
        in_valid1 = 1'b1; in_ctrl1 = c; in_data1 = d;
        exp1_q.push_back({c, d});
    endtask

    task automatic push0(input logic [9:0] c, input logic [159:0] d);
        in_valid0 = 1'b1; in_ctrl0 = c; in_data0 = d;
        exp0_q.push_back({c, d});
    endtask

    // Monitors: retire happens at the next posedge when valid&ready hold at the negedge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!out_valid1) begin
                check("bubble_ctrl1", 170'(out_ctrl1), 170'd0);
            end else if (out_ready1) begin
                if (exp1_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out1: got %0h expected none", {out_ctrl1, out_data1});
                end else begin
                    check("retire1", {out_ctrl1, out_data1}, exp1_q.pop_front());
                end
            end
            if (!out_valid0) begin
                check("bubble_ctrl0", 170'(out_ctrl0), 170'd0);
            end else if (out_ready0) begin
                if (exp0_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out0: got %0h expected none", {out_ctrl0, out_data0});
                end else begin
                    check("retire0", {out_ctrl0, out_data0}, exp0_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        reset = 1'b1;
        in_valid1 = 0; in_ctrl1 = '0; in_data1 = '0; flush1 = 0; out_ready1 = 0;
        in_valid0 = 0; in_ctrl0 = '0; in_data0 = '0; flush0 = 0; out_ready0 = 0;
        step(); step();
        check("rst_out_valid", 170'(out_valid1), 170'd0);
        check("rst_out_ctrl", 170'(out_ctrl1), 170'd0);
        check("rst_out_data", 170'(out_data1), 170'd0);
        check("rst_occ", 170'(occ1), 170'd0);
        check("rst_stall", 170'(stall1), 170'd0);
        check("rst_in_ready", 170'(in_ready1), 170'd1);
        reset = 1'b0;
        mon_en = 1'b1;

        // 1: streaming with out_ready held high
        out_ready1 = 1'b1;
        push1(10'h155, pat(32'hA));
        step(); check("t1_occ_a", 170'(occ1), 170'd1); check("t1_rdy_a", 170'(in_ready1), 170'd1);
        push1(10'h155, pat(32'hB));
        step(); check("t1_occ_b", 170'(occ1), 170'd1); check("t1_rdy_b", 170'(in_ready1), 170'd1);
        push1(10'h155, pat(32'hC));
        step(); check("t1_occ_c", 170'(occ1), 170'd1); check("t1_valid_c", 170'(out_valid1), 170'd1);
        in_valid1 = 1'b0;
        step(); check("t1_drain_occ", 170'(occ1), 170'd0); check("t1_drain_ctrl", 170'(out_ctrl1), 170'd0);

        // 2: backpressure fills skid, third entry held off until space frees
        out_ready1 = 1'b0;
        push1(10'h2aa, pat(32'h1A));
        step(); check("t2_occ1", 170'(occ1), 170'd1);
        push1(10'h0f3, pat(32'h1B));
        step(); check("t2_occ2", 170'(occ1), 170'd2); check("t2_rdy_full", 170'(in_ready1), 170'd0);
        push1(10'h301, pat(32'h1C));
        step(); check("t2_occ_hold", 170'(occ1), 170'd2); check("t2_head_hold", {out_ctrl1, out_data1}, {10'h2aa, pat(32'h1A)});
        step(); check("t2_stall3", 170'(stall1), 170'd3);
        out_ready1 = 1'b1;
        step(); check("t2_occ_after_a", 170'(occ1), 170'd1); check("t2_rdy_back", 170'(in_ready1), 170'd1);
        step(); in_valid1 = 1'b0;
        step(); check("t2_occ_empty", 170'(occ1), 170'd0); check("t2_stall_final", 170'(stall1), 170'd3);

        // 3: flush while full, with a new entry offered in the flush cycle
        out_ready1 = 1'b0;
        push1(10'h011, pat(32'h2E));
        step();
        push1(10'h022, pat(32'h2F));
        step(); check("t3_occ_full", 170'(occ1), 170'd2);
        flush1 = 1'b1; in_valid1 = 1'b1; in_ctrl1 = 10'h3ff; in_data1 = pat(32'h2D);
        step();
        exp1_q.delete();
        flush1 = 1'b0; in_valid1 = 1'b0;
        check("t3_valid", 170'(out_valid1), 170'd0);
        check("t3_ctrl", 170'(out_ctrl1), 170'd0);
        check("t3_occ", 170'(occ1), 170'd0);
        check("t3_rdy", 170'(in_ready1), 170'd1);
        check("t3_stall", 170'(stall1), 170'd5);
        out_ready1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); check("t3_no_d", 170'(out_valid1), 170'd0);
        end

        // 4: reset while full and stalled, with input offered
        out_ready1 = 1'b0;
        push1(10'h044, pat(32'h3A));
        step();
        push1(10'h088, pat(32'h3B));
        step(); check("t4_occ_full", 170'(occ1), 170'd2);
        reset = 1'b1; in_valid1 = 1'b1; in_ctrl1 = 10'h111; in_data1 = pat(32'h3C);
        step();
        exp1_q.delete();
        check("t4_valid", 170'(out_valid1), 170'd0);
        check("t4_ctrl", 170'(out_ctrl1), 170'd0);
        check("t4_data", 170'(out_data1), 170'd0);
        check("t4_occ", 170'(occ1), 170'd0);
        check("t4_stall", 170'(stall1), 170'd0);
        check("t4_rdy", 170'(in_ready1), 170'd1);
        reset = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); check("t4_no_entry", 170'(out_valid1), 170'd0);
        end

        // 5: single-register variant, out_ready 1,0,1 with continuous input
        out_ready0 = 1'b1;
        push0(10'h0a5, pat(32'h40));
        #1 check("t5_rdy_empty", 170'(in_ready0), 170'd1);
        step(); check("t5_occ_k0", 170'(occ0), 170'd1);
        out_ready0 = 1'b0; in_ctrl0 = 10'h05a; in_data0 = pat(32'h41);
        #1 check("t5_rdy_stall", 170'(in_ready0), 170'd0);
        out_ready0 = 1'b1;
        #1 check("t5_rdy_comb", 170'(in_ready0), 170'd1);
        out_ready0 = 1'b0;
        #1;
        step(); check("t5_occ_hold", 170'(occ0), 170'd1); check("t5_head_hold", {out_ctrl0, out_data0}, {10'h0a5, pat(32'h40)});
        out_ready0 = 1'b1;
        push0(10'h05a, pat(32'h41));
        #1 check("t5_rdy_pass", 170'(in_ready0), 170'd1);
        step(); check("t5_occ_k1", 170'(occ0), 170'd1);
        push0(10'h1c3, pat(32'h42));
        step(); check("t5_occ_k2", 170'(occ0), 170'd1);
        in_valid0 = 1'b0;
        step(); check("t5_occ_empty", 170'(occ0), 170'd0);

        // 6: long stall drives stall_cnt to saturation with payload held
        out_ready1 = 1'b0;
        push1(10'h2c9, pat(32'h60));
        step(); in_valid1 = 1'b0;
        bad = 0;
        for (int i = 0; i < 65534; i++) begin
            step();
            if ({out_ctrl1, out_data1} !== {10'h2c9, pat(32'h60)}) bad++;
        end
        check("t6_stall_fffe", 170'(stall1), 170'h0fffe);
        step(); check("t6_stall_ffff", 170'(stall1), 170'h0ffff);
        for (int i = 0; i < 4465; i++) begin
            step();
            if ({out_ctrl1, out_data1} !== {10'h2c9, pat(32'h60)}) bad++;
        end
        check("t6_stall_sat", 170'(stall1), 170'h0ffff);
        check("t6_payload_stable", 170'(bad), 170'd0);
        out_ready1 = 1'b1;
        step(); check("t6_occ_empty", 170'(occ1), 170'd0); check("t6_stall_kept", 170'(stall1), 170'h0ffff);

        step();
        check("q1_drained", 170'(exp1_q.size()), 170'd0);
        check("q0_drained", 170'(exp0_q.size()), 170'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
